// File: rtl/bb_pkg.sv
// Shared constants and types for the DVB-S2 baseband (de)scrambler.
// PRBS polynomial is 1+X^14+X^15; the register is reloaded with PRBS_INIT at every frame start.
package bb_pkg;
  localparam int PRBS_W = 15;
  localparam logic [PRBS_W-1:0] PRBS_INIT = 15'b100101010000000;
  localparam int LEN_W_DEF = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;
endpackage

// File: rtl/bb_descrambler_par_if.sv
// Stream bundle for bb_descrambler_par: input word channel and output word channel.
// Handshake: a word moves when valid & ready are both high on a rising clk edge.
// The sender holds data/tags stable while valid & !ready.
interface bb_descrambler_par_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;

  modport slave (
    input  in_data, in_valid, in_sof, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eof
  );

  modport master (
    output in_data, in_valid, in_sof, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eof
  );
endinterface

// File: rtl/bb_prbs_step.sv
// Unrolled PRBS step: applies the serial law DATA_W times, bit DATA_W-1 first.
// Returns the advanced register and the XORed data word.
module bb_prbs_step
  import bb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [PRBS_W-1:0] state_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [PRBS_W-1:0] state_o,
  output logic [DATA_W-1:0] data_o
);
  logic [PRBS_W-1:0] r;
  logic              key;

  always_comb begin
    r      = state_i;
    key    = 1'b0;
    data_o = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      key       = r[0] ^ r[1];
      data_o[i] = data_i[i] ^ key;
      r         = {key, r[PRBS_W-1:1]};
    end
    state_o = r;
  end
endmodule

// File: rtl/bb_descrambler_par.sv
// Parallel DVB-S2 BB (de)scrambler with frame counter, IDLE/ACTIVE FSM and one output register.
// Optional macro BB_DESCR_FRAME_CHECK_EN adds the frame_err output flag.
module bb_descrambler_par
  import bb_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               LEN_W      = LEN_W_DEF,
  parameter logic [PRBS_W-1:0] INIT_STATE = PRBS_INIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_W-1:0]      k_bch,
  bb_descrambler_par_if.slave   bus,
  output logic                  busy,
  output state_e                dbg_state
`ifdef BB_DESCR_FRAME_CHECK_EN
  ,
  output logic                  frame_err
`endif
);
  localparam int SHIFT = $clog2(DATA_W);
  localparam logic [LEN_W-1:0] LOW_MASK = LEN_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [PRBS_W-1:0] lfsr_q, lfsr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;

  logic              accept, start, last;
  logic [LEN_W-1:0]  nwords, cur_len, cur_idx;
  logic [PRBS_W-1:0] step_state, step_next;
  logic [DATA_W-1:0] step_data;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  // Any accept in IDLE opens a frame; in_sof in ACTIVE resyncs to a new one.
  assign start        = accept & ((state_q == IDLE) | bus.in_sof);
  assign nwords       = k_bch >> SHIFT;
  assign cur_len      = start ? ((nwords == '0) ? LEN_W'(1) : nwords) : len_q;
  assign cur_idx      = start ? '0 : cnt_q;
  assign last         = (cur_idx == cur_len - LEN_W'(1));
  assign step_state   = start ? INIT_STATE : lfsr_q;

  bb_prbs_step #(.DATA_W(DATA_W)) u_step (
    .state_i (step_state),
    .data_i  (bus.in_data),
    .state_o (step_next),
    .data_o  (step_data)
  );

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    if (accept) begin
      out_data_d  = step_data;
      out_valid_d = 1'b1;
      out_sof_d   = start;
      out_eof_d   = last;
      len_d       = cur_len;
      if (last) begin
        lfsr_d  = INIT_STATE;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        lfsr_d  = step_next;
        cnt_d   = cur_idx + LEN_W'(1);
        state_d = ACTIVE;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= INIT_STATE;
      cnt_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

`ifdef BB_DESCR_FRAME_CHECK_EN
  logic ferr_q, ferr_d;

  // Flags a truncated frame (resync) or a k_bch that is not a whole number of words.
  always_comb begin
    ferr_d = ferr_q;
    if (accept) begin
      ferr_d = ((state_q == ACTIVE) & bus.in_sof) | (start & ((k_bch & LOW_MASK) != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end

  assign frame_err = ferr_q;
`else
  logic unused_mask;
  assign unused_mask = ^LOW_MASK;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign busy          = (state_q == ACTIVE);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_bb_descrambler_par.sv
// Self-checking bench for bb_descrambler_par (DATA_W=8 main instance, DATA_W=1 cross-check instance).
// Honours BB_DESCR_FRAME_CHECK_EN when defined for the build.
module tb_bb_descrambler_par;
  import bb_pkg::*;

  localparam logic [14:0] INIT = 15'b100101010000000;
`ifdef BB_DESCR_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] k_bch;
  logic [15:0] k_bch1;
  logic        busy, busy1;
  state_e      dbg_state, dbg_state1;
  logic        frame_err, frame_err1;

  bb_descrambler_par_if #(.DATA_W(8)) bus8 ();
  bb_descrambler_par_if #(.DATA_W(1)) bus1 ();

  bb_descrambler_par #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .k_bch(k_bch), .bus(bus8), .busy(busy), .dbg_state(dbg_state)
`ifdef BB_DESCR_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  bb_descrambler_par #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .k_bch(k_bch1), .bus(bus1), .busy(busy1), .dbg_state(dbg_state1)
`ifdef BB_DESCR_FRAME_CHECK_EN
    , .frame_err(frame_err1)
`endif
  );

`ifndef BB_DESCR_FRAME_CHECK_EN
  assign frame_err  = 1'b0;
  assign frame_err1 = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model + scoreboard ----------------
  logic [10:0] exp_q[$];
  logic [7:0]  col_q[$];
  logic [14:0] m_lfsr = INIT;
  int          m_idx = 0;
  int          m_len = 1;
  bit          m_active = 1'b0;

  function automatic logic [10:0] model_word(input logic [7:0] d, input logic sof, input logic [15:0] k);
    logic [14:0] r;
    logic        key;
    logic [7:0]  o;
    bit          start, last, ferr;
    int          idx;
    start = !m_active || sof;
    ferr  = (m_active && sof) || (start && (k[2:0] != 3'd0));
    if (start) begin
      r     = INIT;
      m_len = ((k >> 3) == 0) ? 1 : int'(k >> 3);
      idx   = 0;
    end else begin
      r   = m_lfsr;
      idx = m_idx;
    end
    for (int b = 7; b >= 0; b--) begin
      key  = r[0] ^ r[1];
      o[b] = d[b] ^ key;
      r    = {key, r[14:1]};
    end
    last     = (idx == m_len - 1);
    m_active = !last;
    m_idx    = idx + 1;
    m_lfsr   = last ? INIT : r;
    return {ferr & FC, start, last, o};
  endfunction

  bit          mon_en = 1'b0;
  bit          stall_q = 1'b0;
  logic [10:0] held_q;
  logic [10:0] cur;
  logic [10:0] e;

  always @(negedge clk) begin
    cur = {frame_err & FC, bus8.out_sof, bus8.out_eof, bus8.out_data};
    if (mon_en) begin
      if (stall_q) begin
        n_vec++;
        if (!bus8.out_valid || cur !== held_q) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b %h, required v=1 %h", bus8.out_valid, cur, held_q);
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h, required no output", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_err++;
            $display("FAIL out_word: got {ferr,sof,eof,data}=%h, required %h", cur, e);
          end
        end
        col_q.push_back(bus8.out_data);
      end
      stall_q = bus8.out_valid && !bus8.out_ready;
      held_q  = cur;
    end else begin
      stall_q = 1'b0;
    end
  end

  bit bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    bus8.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [7:0] d, input logic sof);
    int t = 0;
    bus8.in_data  = d;
    bus8.in_sof   = sof;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    while (!bus8.in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!bus8.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0, required 1 within 1000 cycles");
    end else begin
      exp_q.push_back(model_word(d, sof, k_bch));
    end
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_sof   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus8.out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0 || bus8.out_valid) begin
      n_err++;
      $display("FAIL drain: got %0d words pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_vec += 7;
    if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", bus8.out_valid); end
    if (bus8.out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h, required 00", bus8.out_data); end
    if (bus8.out_sof !== 1'b0)   begin n_err++; $display("FAIL rst_out_sof: got %b, required 0", bus8.out_sof); end
    if (bus8.out_eof !== 1'b0)   begin n_err++; $display("FAIL rst_out_eof: got %b, required 0", bus8.out_eof); end
    if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (bus8.in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", bus8.in_ready); end
    if (dbg_state !== IDLE)      begin n_err++; $display("FAIL rst_state: got %0d, required IDLE", dbg_state); end
    if (FC) begin
      n_vec++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b, required 0", frame_err); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_keystream();
    k_bch = 16'd64;
    col_q.delete();
    for (int w = 0; w < 8; w++) send(8'h00, w == 0);
    drain();
    n_vec += 3;
    if (col_q.size() != 8) begin n_err++; $display("FAIL ks_count: got %0d, required 8", col_q.size()); end
    if (col_q.size() > 0 && col_q[0] !== 8'h03) begin n_err++; $display("FAIL ks_word0: got %h, required 03", col_q[0]); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL ks_busy_after: got %b, required 0", busy); end
  endtask

  logic [7:0] src[250];
  logic [7:0] scr[250];

  task automatic test_random_frame();
    int nb;
    logic [7:0] b;
    logic [1:0] tag;
    k_bch = 16'd2000;
    col_q.delete();
    for (int i = 0; i < 250; i++) begin
      src[i] = 8'($urandom_range(0, 255));
      send(src[i], i == 0);
    end
    drain();
    for (int i = 0; i < 250; i++) scr[i] = (i < col_q.size()) ? col_q[i] : 8'hxx;
    // re-scramble the scrambled frame: must restore the source bytes
    col_q.delete();
    for (int i = 0; i < 250; i++) send(scr[i], i == 0);
    drain();
    for (int i = 0; i < 250; i++) begin
      n_vec++;
      b = (i < col_q.size()) ? col_q[i] : 8'hxx;
      if (b !== src[i]) begin n_err++; $display("FAIL rescramble[%0d]: got %h, required %h", i, b, src[i]); end
    end
    // same bits through the 1-bit instance, earliest bit = bit 7
    nb = 0;
    for (int i = 0; i <= 2003; i++) begin
      bus1.in_valid = (i < 2000);
      bus1.in_sof   = (i == 0);
      bus1.in_data  = (i < 2000) ? src[i / 8][7 - (i % 8)] : 1'b0;
      @(negedge clk);
      if (bus1.out_valid) begin
        tag = {bus1.out_sof, bus1.out_eof};
        if (nb == 0 || nb == 1999) begin
          n_vec++;
          if (tag !== ((nb == 0) ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL w1_tags[%0d]: got sof,eof=%b, required %b", nb, tag, (nb == 0) ? 2'b10 : 2'b01);
          end
        end
        if (nb < 2000) b[7 - (nb % 8)] = bus1.out_data[0];
        nb++;
        if (nb % 8 == 0 && nb <= 2000) begin
          n_vec++;
          if (b !== scr[nb / 8 - 1]) begin
            n_err++;
            $display("FAIL w1_vs_w8[%0d]: got %h, required %h", nb / 8 - 1, b, scr[nb / 8 - 1]);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (nb != 2000) begin n_err++; $display("FAIL w1_count: got %0d, required 2000", nb); end
  endtask

  task automatic test_back_to_back();
    k_bch = 16'd128;
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 16; w++) begin
        send(8'($urandom_range(0, 255)), w == 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
    bp_en = 1'b0;
  endtask

  task automatic test_resync();
    k_bch = 16'd128;
    col_q.delete();
    for (int w = 0; w < 21; w++) send(8'h00, (w == 0) || (w == 5));
    drain();
    n_vec += 2;
    if (col_q.size() != 21) begin n_err++; $display("FAIL resync_count: got %0d, required 21", col_q.size()); end
    if (col_q.size() > 5 && col_q[5] !== 8'h03) begin n_err++; $display("FAIL resync_word5: got %h, required 03", col_q[5]); end
  endtask

  task automatic test_short_frames();
    k_bch = 16'd4;
    for (int w = 0; w < 3; w++) send(8'(w * 37), 1'b0);
    drain();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL short_busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    k_bch = 16'd128;
    col_q.delete();
    for (int w = 0; w < 3; w++) send(8'($urandom_range(0, 255)), w == 0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    @(negedge clk);
    n_vec += 2;
    if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, required 0", bus8.out_valid); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    @(posedge clk);
    #1;
    col_q.delete();
    mon_en = 1'b1;
    for (int w = 0; w < 16; w++) send(8'h00, 1'b0);
    drain();
    n_vec++;
    if (col_q.size() < 1 || col_q[0] !== 8'h03) begin
      n_err++;
      $display("FAIL midrst_restart: got %h, required 03", (col_q.size() > 0) ? col_q[0] : 8'hxx);
    end
  endtask

  initial begin
    k_bch         = 16'd64;
    k_bch1        = 16'd2000;
    bus8.in_data  = '0;
    bus8.in_valid = 1'b0;
    bus8.in_sof   = 1'b0;
    bus8.out_ready = 1'b1;
    bus1.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_sof   = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_keystream();
    test_random_frame();
    test_back_to_back();
    test_resync();
    test_short_frames();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
